// File: rtl/rd_stream_ctrl.sv
// ---------------------------------------------------------------------------
// rd_stream_ctrl
// Splits a read job of total_beats beats into requests of at most BURST_LEN
// beats, issues them one at a time to a downstream read engine, and buffers
// the returned beats in a show-ahead FIFO that feeds a valid/ready stream.
// A request is only issued once the FIFO has room for every beat it can
// return.
//
// Ports
//   clk, rst_n        single clock, asynchronous active-low reset
//   init_end          memory initialisation complete (gates start)
//   start             one-cycle job request
//   base_addr         address of the first beat of the job
//   total_beats       number of beats in the job
//   busy              job in progress
//   done              one-cycle job-complete pulse
//   ovf_err           sticky flag: stray beat or beat arriving into a full FIFO
//   rd_trig           one-cycle read request pulse
//   rd_len, rd_addr   current request length/address, stable until rd_done
//   rd_ready          read engine idle
//   rd_done           read engine request-complete pulse
//   rd_data_en        returned beat valid
//   rd_data           returned beat
//   m_valid, m_data   output stream (show-ahead FIFO head)
//   m_ready           output stream accept
// ---------------------------------------------------------------------------
module rd_stream_ctrl #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int ADDR_STEP  = 1,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           total_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_err,
    output logic                  rd_trig,
    output logic [7:0]            rd_len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_ready,
    input  logic                  rd_done,
    input  logic                  rd_data_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SPACE,
        REQ,
        WAIT,
        DRAIN,
        FINISH
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [15:0]           total_q;
    logic [15:0]           remaining_q;
    logic [15:0]           received_q;
    logic [7:0]            cur_len_q;
    logic [7:0]            len_calc;
    logic                  ovf_q;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d, free_slots;

    logic start_ok;
    logic push_req, push_ok, pop;
    logic full, empty;
    logic received_all;
    logic last_burst;

    assign start_ok     = (state_q == IDLE) && start && init_end;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FINISH);
    assign ovf_err      = ovf_q;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign free_slots   = CNT_W'(FIFO_DEPTH) - count_q;
    assign m_valid      = !empty;
    // Gate the head entry so the stream data reads as zero whenever nothing is
    // buffered, which also gives the zero value during reset without having to
    // clear the storage array.
    assign m_data       = m_valid ? mem[rd_ptr_q] : '0;
    assign pop          = m_valid && m_ready;
    // A full FIFO still accepts a beat when the head is leaving in the same cycle.
    assign push_req     = rd_data_en && busy;
    assign push_ok      = push_req && (!full || pop);

    assign len_calc     = (remaining_q > 16'(BURST_LEN)) ? 8'(BURST_LEN) : remaining_q[7:0];
    assign received_all = (received_q >= total_q);
    assign last_burst   = (remaining_q <= {8'd0, cur_len_q});
    assign addr_inc     = ADDR_WIDTH'(32'(cur_len_q) * ADDR_STEP);

    assign rd_trig      = (state_q == REQ) && rd_ready;
    assign rd_len       = cur_len_q;
    assign rd_addr      = addr_q;

    // Occupancy after this cycle's push/pop; used so the job can finish the
    // cycle right after the final beat leaves instead of one cycle later.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = (total_beats == 16'd0) ? FINISH : SPACE;
                end
            end
            SPACE: begin
                if (32'(free_slots) >= 32'(len_calc)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (rd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rd_done) begin
                    if (!last_burst) begin
                        state_d = SPACE;
                    end else if (received_all && (count_d == '0)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (received_all && (count_d == '0)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Job bookkeeping: address/remaining advance only on rd_done so rd_addr and
    // rd_len stay put for the whole outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            total_q     <= '0;
            remaining_q <= '0;
            received_q  <= '0;
            cur_len_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                addr_q      <= base_addr;
                total_q     <= total_beats;
                remaining_q <= total_beats;
                received_q  <= '0;
                ovf_q       <= 1'b0;
            end
            if ((state_q == SPACE) && (state_d == REQ)) begin
                cur_len_q <= len_calc;
            end
            if ((state_q == WAIT) && rd_done) begin
                addr_q      <= addr_q + addr_inc;
                remaining_q <= remaining_q - {8'd0, cur_len_q};
            end
            if (push_ok) begin
                received_q <= received_q + 16'd1;
            end
            if (rd_data_en && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= rd_data;
        end
    end

endmodule

// File: tb/tb_rd_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rd_stream_ctrl
// Self-checking bench for rd_stream_ctrl. A read-engine model answers each
// rd_trig with rd_len random beats and an rd_done pulse; every beat it sends
// is queued as the expected stream output. Expected requests for a job are
// derived from (base, total) by plain splitting arithmetic. Monitors compare
// stream beats, requests and done timing against those queues.
// ---------------------------------------------------------------------------
module tb_rd_stream_ctrl;

    localparam int ADDR_WIDTH = 26;
    localparam int DATA_WIDTH = 32;
    localparam int BURST_LEN  = 8;
    localparam int ADDR_STEP  = 1;
    localparam int FIFO_DEPTH = 64;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  init_end = 1'b0;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic [15:0]           total_beats = '0;
    logic                  busy, done, ovf_err, rd_trig;
    logic [7:0]            rd_len;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready = 1'b1;
    logic                  rd_done = 1'b0;
    logic                  rd_data_en = 1'b0;
    logic [DATA_WIDTH-1:0] rd_data = '0;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready = 1'b0;

    int check_count = 0;
    int pass_count = 0;
    int cycle = 0;
    int trig_count = 0;
    int done_count = 0;
    int done_cycle = -1;
    int last_pop_cycle = -1;
    int ready_mode = 0;
    bit engine_busy = 1'b0;

    logic [DATA_WIDTH-1:0] exp_data[$];
    logic [ADDR_WIDTH-1:0] exp_addr[$];
    logic [7:0]            exp_len[$];

    rd_stream_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .BURST_LEN (BURST_LEN),
        .ADDR_STEP (ADDR_STEP),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_end   (init_end),
        .start      (start),
        .base_addr  (base_addr),
        .total_beats(total_beats),
        .busy       (busy),
        .done       (done),
        .ovf_err    (ovf_err),
        .rd_trig    (rd_trig),
        .rd_len     (rd_len),
        .rd_addr    (rd_addr),
        .rd_ready   (rd_ready),
        .rd_done    (rd_done),
        .rd_data_en (rd_data_en),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference split of a job into requests: chunks of at most BURST_LEN,
    // address advancing by len*ADDR_STEP and wrapping at the address width.
    task automatic push_expected_requests(input logic [ADDR_WIDTH-1:0] base, input int total);
        logic [ADDR_WIDTH-1:0] a;
        int rem;
        int len;
        a   = base;
        rem = total;
        while (rem > 0) begin
            len = (rem < BURST_LEN) ? rem : BURST_LEN;
            exp_addr.push_back(a);
            exp_len.push_back(8'(len));
            a = a + ADDR_WIDTH'(len * ADDR_STEP);
            rem -= len;
        end
    endtask

    task automatic apply_stimulus(input logic [ADDR_WIDTH-1:0] base, input logic [15:0] total);
        @(posedge clk); #1;
        base_addr   = base;
        total_beats = total;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for the job's done pulse, then checks completion state.
    task automatic finish_job(input int done_before, input int trig_before, input int total, input int budget);
        int t;
        t = 0;
        while ((done_count == done_before) && (t < budget)) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check_output("done_pulses", 64'(done_count - done_before), 64'd1);
        check_output("done_after_last_pop", 64'(done_cycle), 64'(last_pop_cycle + 1));
        check_output("trig_total", 64'(trig_count - trig_before), 64'((total + BURST_LEN - 1) / BURST_LEN));
        check_output("busy_after_done", busy, 64'd0);
        check_output("beats_left", 64'(exp_data.size()), 64'd0);
        check_output("reqs_left", 64'(exp_addr.size()), 64'd0);
    endtask

    task automatic run_job(input logic [ADDR_WIDTH-1:0] base, input int total, input int mode);
        int done_before, trig_before;
        ready_mode  = mode;
        done_before = done_count;
        trig_before = trig_count;
        push_expected_requests(base, total);
        apply_stimulus(base, 16'(total));
        @(negedge clk);
        check_output("busy_after_start", busy, 64'd1);
        check_output("ovf_clear_on_start", ovf_err, 64'd0);
        finish_job(done_before, trig_before, total, total * 8 + 200);
    endtask

    // Stream output ready generator.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 3) != 0);
                2: m_ready = 1'b0;
                default: ;
            endcase
        end
    end

    // Read engine model: serves one request at a time with random beat gaps.
    initial begin : read_engine
        logic [ADDR_WIDTH-1:0] req_addr;
        logic [7:0]            req_len;
        logic [DATA_WIDTH-1:0] beat;
        bit                    abort;
        forever begin
            @(negedge clk);
            if ((rst_n === 1'b1) && (rd_trig === 1'b1)) begin
                engine_busy = 1'b1;
                trig_count++;
                req_addr = rd_addr;
                req_len  = rd_len;
                check_output("trig_with_ready", rd_ready, 64'd1);
                if (exp_addr.size() == 0) begin
                    check_output("unexpected_trig", 64'd1, 64'd0);
                end else begin
                    check_output("req_addr", rd_addr, exp_addr.pop_front());
                    check_output("req_len", rd_len, exp_len.pop_front());
                end
                abort = 1'b0;
                @(posedge clk); #1;
                rd_ready = 1'b0;
                for (int i = 0; i < int'(req_len) && !abort; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    if (rst_n !== 1'b1) begin
                        abort = 1'b1;
                    end else begin
                        beat       = $urandom;
                        rd_data    = beat;
                        rd_data_en = 1'b1;
                        exp_data.push_back(beat);
                        @(posedge clk); #1;
                        rd_data_en = 1'b0;
                        if (rst_n === 1'b1) begin
                            check_output("rd_addr_hold", rd_addr, req_addr);
                            check_output("rd_len_hold", rd_len, req_len);
                            check_output("one_outstanding", rd_trig, 64'd0);
                        end
                    end
                end
                if (!abort && (rst_n === 1'b1)) begin
                    rd_done = 1'b1;
                    @(posedge clk); #1;
                    rd_done = 1'b0;
                end
                rd_data_en  = 1'b0;
                rd_ready    = 1'b1;
                engine_busy = 1'b0;
            end else begin
                @(posedge clk); #1;
                rd_ready = ($urandom_range(0, 4) != 0);
            end
        end
    end

    // Stream monitor: ordered beat comparison and hold-under-stall checks.
    initial begin : stream_monitor
        logic                  prev_stall;
        logic [DATA_WIDTH-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_output("stall_valid_hold", m_valid, 64'd1);
                    check_output("stall_data_hold", m_data, prev_data);
                end
                if (m_valid && m_ready) begin
                    if (exp_data.size() == 0) begin
                        check_output("unexpected_beat", 64'd1, 64'd0);
                    end else begin
                        check_output("beat_data", m_data, exp_data.pop_front());
                    end
                    last_pop_cycle = cycle;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                done_cycle = cycle;
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"}, busy, 64'd0);
        check_output({tag, "_done"}, done, 64'd0);
        check_output({tag, "_ovf_err"}, ovf_err, 64'd0);
        check_output({tag, "_rd_trig"}, rd_trig, 64'd0);
        check_output({tag, "_rd_len"}, rd_len, 64'd0);
        check_output({tag, "_rd_addr"}, rd_addr, 64'd0);
        check_output({tag, "_m_valid"}, m_valid, 64'd0);
        check_output({tag, "_m_data"}, m_data, 64'd0);
    endtask

    initial begin : main
        int done_before, trig_before, t;
        bit busy_seen;

        #2 rst_n = 1'b0;
        init_end = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] burst split job");
        run_job(26'h100, 20, 0);

        $display("[TB] zero-length job");
        ready_mode  = 0;
        trig_before = trig_count;
        apply_stimulus(26'h200, 16'd0);
        @(negedge clk);
        check_output("zero_done", done, 64'd1);
        @(negedge clk);
        check_output("zero_done_low", done, 64'd0);
        check_output("zero_busy_low", busy, 64'd0);
        repeat (5) @(negedge clk);
        check_output("zero_no_trig", 64'(trig_count - trig_before), 64'd0);

        $display("[TB] init gating");
        init_end    = 1'b0;
        trig_before = trig_count;
        apply_stimulus(26'h500, 16'd5);
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            busy_seen |= busy;
        end
        check_output("gated_busy", 64'(busy_seen), 64'd0);
        check_output("gated_no_trig", 64'(trig_count - trig_before), 64'd0);
        init_end = 1'b1;

        $display("[TB] stray beat");
        @(posedge clk); #1;
        rd_data    = 32'hDEADBEEF;
        rd_data_en = 1'b1;
        @(posedge clk); #1;
        rd_data_en = 1'b0;
        @(negedge clk);
        check_output("stray_ovf_set", ovf_err, 64'd1);
        check_output("stray_no_valid", m_valid, 64'd0);
        repeat (3) @(negedge clk);
        check_output("stray_ovf_sticky", ovf_err, 64'd1);
        run_job(26'h300, 3, 0);

        $display("[TB] backpressure");
        ready_mode  = 2;
        done_before = done_count;
        trig_before = trig_count;
        push_expected_requests(26'h1000, 100);
        apply_stimulus(26'h1000, 16'd100);
        t = 0;
        while (!((trig_count - trig_before == 8) && !engine_busy) && (t < 800)) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        check_output("bp_trigs_when_full", 64'(trig_count - trig_before), 64'd8);
        check_output("bp_beats_buffered", 64'(exp_data.size()), 64'd64);
        check_output("bp_valid", m_valid, 64'd1);
        ready_mode = 3;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
        repeat (10) @(negedge clk);
        check_output("bp_no_resume_after_7", 64'(trig_count - trig_before), 64'd8);
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        t = 0;
        while ((trig_count - trig_before < 9) && (t < 40)) begin
            @(negedge clk);
            t++;
        end
        check_output("bp_resume_after_8", 64'(trig_count - trig_before), 64'd9);
        ready_mode = 1;
        finish_job(done_before, trig_before, 100, 3000);

        $display("[TB] random jobs");
        for (int j = 0; j < 6; j++) begin
            run_job(ADDR_WIDTH'($urandom), $urandom_range(1, 40), 1);
        end
        run_job(26'h3FFFFFC, 10, 1);

        $display("[TB] reset mid-burst");
        ready_mode = 1;
        push_expected_requests(26'h2000, 50);
        apply_stimulus(26'h2000, 16'd50);
        t = 0;
        while (!engine_busy && (t < 100)) begin
            @(negedge clk);
            t++;
        end
        check_output("mid_engine_started", 64'(engine_busy), 64'd1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        t = 0;
        while (engine_busy && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        exp_data.delete();
        exp_addr.delete();
        exp_len.delete();
        trig_before = trig_count;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_output("after_reset_no_trig", 64'(trig_count - trig_before), 64'd0);
        check_output("after_reset_idle", busy, 64'd0);
        run_job(26'h40, 12, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/rd_stream_ctrl.md
RD_STREAM_CTRL -- requirements
Module: rd_stream_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 26, read address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data beat width.
REQ-003 SHALL have parameter BURST_LEN, default 8, maximum beats per read request (1..255).
REQ-004 SHALL have parameter ADDR_STEP, default 1, address increment per beat.
REQ-005 SHALL have parameter FIFO_DEPTH, default 64, power of two, at least BURST_LEN.
REQ-006 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- init_end  in  1  memory initialisation complete.
- start  in  1  one-cycle job request.
- base_addr  in  ADDR_WIDTH  first beat address.
- total_beats  in  16  beats in the job.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- ovf_err  out  1  sticky stray or overflow beat flag.
- rd_trig  out  1  one-cycle read request pulse.
- rd_len  out  8  beats in the current request.
- rd_addr  out  ADDR_WIDTH  current request address.
- rd_ready  in  1  downstream read engine idle.
- rd_done  in  1  read engine request-complete pulse.
- rd_data_en  in  1  returned beat valid.
- rd_data  in  DATA_WIDTH  returned beat.
- m_valid  out  1  output stream valid.
- m_data  out  DATA_WIDTH  output stream data.
- m_ready  in  1  output stream accept.

Function
REQ-007 SHALL have states IDLE, SPACE, REQ, WAIT, DRAIN and FINISH.
REQ-008 IDLE: on start=1 with init_end=1, SHALL latch base_addr and total_beats, clear ovf_err and set busy=1; if total_beats=0, go to FINISH, otherwise go to SPACE.
REQ-009 IDLE: SHALL ignore start while init_end=0; SHALL ignore start while busy=1.
REQ-010 SPACE: SHALL compute cur_len = min(remaining, BURST_LEN); go to REQ when FIFO free slots >= cur_len.
REQ-011 REQ: SHALL pulse rd_trig for exactly one cycle, in the first cycle rd_ready=1, with rd_len=cur_len and rd_addr=current address; then go to WAIT.
REQ-012 rd_addr and rd_len SHALL hold stable from the rd_trig cycle until rd_done.
REQ-013 WAIT: on rd_done=1, SHALL set address += cur_len*ADDR_STEP, modulo 2^ADDR_WIDTH (wraps silently).
REQ-014 WAIT: on rd_done=1, SHALL set remaining -= cur_len; go to SPACE if remaining>0, otherwise go to DRAIN.
REQ-015 At most one request SHALL be outstanding at any time.
REQ-016 While busy=1, every rd_data_en=1 cycle SHALL push rd_data into the FIFO; beat order SHALL be preserved.
REQ-017 DRAIN: SHALL wait until all total_beats have been received and the FIFO is empty, then go to FINISH.
REQ-018 FINISH: SHALL pulse done=1 for one cycle, set busy=0 and return to IDLE; done SHALL assert the cycle after the final m handshake, or 1 cycle after start when total_beats=0.
REQ-019 FIFO SHALL be show-ahead: m_valid=1 whenever non-empty, m_data=head entry, pop on m_valid&m_ready.
REQ-020 A beat pushed into an empty FIFO at cycle N SHALL appear on m_valid at cycle N+1.
REQ-021 Push and pop in the same cycle SHALL both succeed, including when full, leaving the count unchanged.
REQ-022 rd_data_en=1 while busy=0, or while the FIFO is full without a pop, SHALL discard the beat and set ovf_err=1.
REQ-023 ovf_err SHALL hold until the next accepted start.
REQ-024 m_data SHALL hold stable while m_valid=1 and m_ready=0.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, an empty FIFO and the counters to 0.
REQ-026 rst_n=0 SHALL immediately force busy=0, done=0, ovf_err=0, rd_trig=0, rd_len=0, rd_addr=0, m_valid=0 and m_data=0, including mid-job.
REQ-027 After rst_n rises, the block SHALL wait for a new start; no request SHALL resume.

Verification
REQ-028 Burst split: base_addr=0x100, total_beats=20, m_ready=1 -> three rd_trig with (addr,len) = (0x100,8), (0x108,8), (0x110,4); 20 beats out in order; done pulsed once.
REQ-029 Zero-length job: start with total_beats=0 -> done=1 one cycle later; no rd_trig.
REQ-030 Backpressure: total_beats=100, m_ready=0 -> rd_trig stops after 64 beats buffered; resumes only after 8 pops.
REQ-031 Stray beat: rd_data_en=1 while busy=0 -> ovf_err=1 and m_valid stays 0; next accepted start clears ovf_err.
REQ-032 Init gating: start while init_end=0 -> busy stays 0; no rd_trig.
REQ-033 Reset mid-burst: rst_n=0 during WAIT -> all outputs reach reset values in the same cycle; after release, no rd_trig occurs until a new start.
